// File: rtl/stoch_arb_pkg.sv
// Shared types and helpers for the stochastic subtractor arbiter.
//   state_t        : arbiter FSM states
//   DEFAULT_LEN_W  : default width of the job length field
//   flush_cnt_w()  : width of the counter that times the flush window
package stoch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_LEN_W = 16;

  // Counter runs 0 .. flush_cycles-1; a single-cycle flush still needs a 1-bit counter.
  function automatic int unsigned flush_cnt_w(input int unsigned flush_cycles);
    return (flush_cycles > 1) ? $clog2(flush_cycles) : 1;
  endfunction

endpackage

// File: rtl/stoch_rr_arbiter.sv
// Combinational round-robin pick.
//   req   : request vector
//   ptr   : index of the last served requester; search starts at (ptr+1) mod NUM_REQ
//   gnt   : one-hot winner, zero when nothing is requested
//   valid : at least one request was found
module stoch_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stoch_sat_sub_mat_arb.sv
// Shares one external stoch_sat_sub_mat among NUM_REQ requesters. Each job is a
// bitstream of len cycles; the subtractor is cleared for FLUSH_CYCLES before every job.
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   req, len      : per-requester level request and job length (len sampled at grant)
//   A_in, B_in    : per-requester operand bitstreams (NUM_ROWS*NUM_COLS bits each)
//   grant         : one-hot owner during FLUSH/RUN
//   y_valid, done : per-requester result strobe and one-cycle completion pulse
//   Y_out         : result bitstream, zero outside RUN
//   sub_rst, sub_A, sub_B, sub_Y : connection to the shared subtractor
// Build option: define STOCH_SUB_ARB_ABORT_EN to let the owner abort a job by
// dropping req during FLUSH or RUN.
module stoch_sat_sub_mat_arb
  import stoch_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned NUM_ROWS     = 2,
  parameter int unsigned NUM_COLS     = 2,
  parameter int unsigned LEN_W        = DEFAULT_LEN_W,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*LEN_W-1:0]             len,
  input  logic [NUM_REQ*NUM_ROWS*NUM_COLS-1:0] A_in,
  input  logic [NUM_REQ*NUM_ROWS*NUM_COLS-1:0] B_in,
  output logic [NUM_REQ-1:0]                   grant,
  output logic [NUM_REQ-1:0]                   y_valid,
  output logic [NUM_REQ-1:0]                   done,
  output logic [NUM_ROWS*NUM_COLS-1:0]         Y_out,
  output logic                                 sub_rst,
  output logic [NUM_ROWS*NUM_COLS-1:0]         sub_A,
  output logic [NUM_ROWS*NUM_COLS-1:0]         sub_B,
  input  logic [NUM_ROWS*NUM_COLS-1:0]         sub_Y
);

  localparam int unsigned M      = NUM_ROWS * NUM_COLS;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned FCNT_W = flush_cnt_w(FLUSH_CYCLES);
  localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_RST    = PTR_W'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic [LEN_W-1:0]     len_cnt_q, len_cnt_d;
  logic [FCNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_valid;
  logic [PTR_W-1:0]     owner_idx;
  logic [LEN_W-1:0]     len_sel;
  logic [M-1:0]         a_sel, b_sel;
  logic                 in_run;
  logic                 abort;

  stoch_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Selection muxes: len by the fresh arbiter winner, data by the registered owner.
  always_comb begin
    owner_idx = '0;
    len_sel   = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (owner_q[r]) begin
        owner_idx = PTR_W'(r);
        a_sel     = A_in[r*M +: M];
        b_sel     = B_in[r*M +: M];
      end
      if (arb_gnt[r]) len_sel = len[r*LEN_W +: LEN_W];
    end
  end

`ifdef STOCH_SUB_ARB_ABORT_EN
  assign abort = ~|(req & owner_q);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    len_cnt_d   = len_cnt_q;
    flush_cnt_d = flush_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        flush_cnt_d = '0;
        if (arb_valid) begin
          owner_d   = arb_gnt;
          len_cnt_d = len_sel;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        if (abort) begin
          state_d = DONE;
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d = (len_cnt_q != '0) ? RUN : DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + FCNT_W'(1);
        end
      end
      RUN: begin
        len_cnt_d = len_cnt_q - LEN_W'(1);
        // Leaving at 1 means the counter never wraps, even for the all-ones length.
        if (abort || len_cnt_q == LEN_W'(1)) state_d = DONE;
      end
      DONE: begin
        rr_ptr_d = owner_idx;
        owner_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      len_cnt_q   <= '0;
      flush_cnt_q <= '0;
      rr_ptr_q    <= PTR_RST;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      len_cnt_q   <= len_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    in_run  = (state_q == RUN);
    grant   = (state_q == FLUSH || in_run) ? owner_q : '0;
    done    = (state_q == DONE) ? owner_q : '0;
    sub_rst = ~in_run;
    sub_A   = in_run ? a_sel : '0;
    sub_B   = in_run ? b_sel : '0;
    Y_out   = in_run ? sub_Y : '0;
`ifdef STOCH_SUB_ARB_ABORT_EN
    // The aborting cycle itself carries no valid result.
    y_valid = in_run ? (owner_q & req) : '0;
`else
    y_valid = in_run ? owner_q : '0;
`endif
  end

endmodule

// File: tb/tb_stoch_sat_sub_mat_arb.sv
module tb_stoch_sat_sub_mat_arb;

  localparam int N  = 2;
  localparam int M  = 4;
  localparam int LW = 16;
  localparam int FC = 2;
  localparam int W  = 3 * N + 1 + 3 * M;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req;
  logic [N*LW-1:0] len;
  logic [N*M-1:0] A_in, B_in;
  logic [N-1:0]   grant, y_valid, done;
  logic [M-1:0]   Y_out, sub_A, sub_B, sub_Y;
  logic           sub_rst;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  // Behavioural stand-in for the shared saturating subtractor (unipolar A and not B).
  assign sub_Y = sub_A & ~sub_B;

  wire [W-1:0] obs = {grant, y_valid, done, sub_rst, Y_out, sub_A, sub_B};

  stoch_sat_sub_mat_arb dut (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .len     (len),
    .A_in    (A_in),
    .B_in    (B_in),
    .grant   (grant),
    .y_valid (y_valid),
    .done    (done),
    .Y_out   (Y_out),
    .sub_rst (sub_rst),
    .sub_A   (sub_A),
    .sub_B   (sub_B),
    .sub_Y   (sub_Y)
  );

  // Expected output bundle for one cycle, built from the bench's own drive values.
  function automatic logic [W-1:0] exp_vec(input int owner, input bit gnt, input bit run,
                                           input bit vld, input bit dn);
    logic [N-1:0] oh;
    logic [M-1:0] a, b;
    oh = '0;
    a  = '0;
    b  = '0;
    if (owner >= 0) oh = N'(1) << owner;
    if (run) begin
      a = M'(A_in >> (owner * M));
      b = M'(B_in >> (owner * M));
    end
    return {gnt ? oh : {N{1'b0}}, vld ? oh : {N{1'b0}}, dn ? oh : {N{1'b0}},
            ~run, a & ~b, a, b};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    RST  = 1'b1;
    req  = '0;
    len  = '0;
    A_in = (N*M)'($urandom);
    B_in = (N*M)'($urandom);
    tick();
    #4;
    e = exp_vec(-1, 0, 0, 0, 0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", obs, e);
    end
    req = '1;
    tick();
    #4;
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_ignores_req got=%h exp=%h", obs, e);
    end
    tick();
    RST = 1'b0;
    req = '0;
  endtask

  task automatic test_single_job();
    do_reset();
    len = '0;
    len[LW-1:0] = 16'd4;
    A_in[M-1:0] = 4'hF;
    B_in[M-1:0] = 4'h0;
    A_in[2*M-1:M] = M'($urandom);
    B_in[2*M-1:M] = M'($urandom);
    req = 2'b01;
    for (int c = 0; c < 11; c++) begin
      bit g, r, dn;
      logic [W-1:0] e;
      if (c == 8) req = '0;
      g  = (c >= 1 && c <= FC + 4);
      r  = (c >= FC + 1 && c <= FC + 4);
      dn = (c == FC + 5);
      #4;
      e = exp_vec(0, g, r, r, dn);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL single_job c=%0d got=%h exp=%h", c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    do_reset();
    len = {16'd3, 16'd3};
    A_in = {M'($urandom), 4'hF};
    B_in = {M'($urandom), 4'h0};
    req = 2'b11;
    for (int c = 0; c < 17; c++) begin
      int s, o, d;
      bit g, r, dn;
      logic [W-1:0] e;
      if (c == 7)  req[0] = 1'b0;
      if (c == 14) req[1] = 1'b0;
      s  = (c < 7) ? 0 : 7;
      o  = (c < 7) ? 0 : 1;
      d  = c - s;
      g  = (d >= 1 && d <= FC + 3);
      r  = (d >= FC + 1 && d <= FC + 3);
      dn = (d == FC + 4);
      #4;
      e = exp_vec(o, g, r, r, dn);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL contention c=%0d got=%h exp=%h", c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    do_reset();
    len = {16'd2, 16'd2};
    A_in = (N*M)'($urandom);
    B_in = (N*M)'($urandom);
    req = 2'b01;
    for (int c = 0; c < 20; c++) begin
      int s, o, d;
      bit g, r, dn;
      logic [W-1:0] e;
      if (c == 2)  req[1] = 1'b1;
      if (c == 12) req[1] = 1'b0;
      if (c == 18) req[0] = 1'b0;
      s  = (c < 6) ? 0 : (c < 12) ? 6 : 12;
      o  = (c >= 6 && c < 12) ? 1 : 0;
      d  = c - s;
      g  = (d >= 1 && d <= FC + 2);
      r  = (d >= FC + 1 && d <= FC + 2);
      dn = (d == FC + 3);
      #4;
      e = exp_vec(o, g, r, r, dn);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL fairness c=%0d got=%h exp=%h", c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    len = '0;
    A_in = '1;
    B_in = '0;
    req = 2'b01;
    for (int c = 0; c < 7; c++) begin
      logic [W-1:0] e;
      if (c == 4) req = '0;
      #4;
      e = exp_vec(0, (c >= 1 && c <= FC), 0, 0, (c == FC + 1));
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL zero_len c=%0d got=%h exp=%h", c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] e;
    do_reset();
    len = {16'd3, 16'd6};
    A_in = (N*M)'($urandom);
    B_in = (N*M)'($urandom);
    req = 2'b11;
    for (int c = 0; c < 5; c++) begin
      bit g, r;
      g = (c >= 1);
      r = (c >= FC + 1);
      #4;
      e = exp_vec(0, g, r, r, 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_run_lead c=%0d got=%h exp=%h", c, obs, e);
      end
      tick();
    end
    #2;
    RST = 1'b1;
    #2;
    e = exp_vec(-1, 0, 0, 0, 0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL mid_run_async_reset got=%h exp=%h", obs, e);
    end
    tick();
    #4;
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL mid_run_no_done got=%h exp=%h", obs, e);
    end
    tick();
    RST = 1'b0;
    #4;
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL mid_run_idle_after got=%h exp=%h", obs, e);
    end
    tick();
    #4;
    e = exp_vec(0, 1, 0, 0, 0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL mid_run_regrant got=%h exp=%h", obs, e);
    end
    tick();
    req = '0;
  endtask

  task automatic test_abort_drop();
    do_reset();
    len = '0;
    len[LW-1:0] = 16'd10;
    A_in = (N*M)'($urandom);
    B_in = (N*M)'($urandom);
    req = 2'b01;
    for (int c = 0; c < 17; c++) begin
      bit g, r, v, dn;
      logic [W-1:0] e;
      if (c == 6) req = '0;
`ifdef STOCH_SUB_ARB_ABORT_EN
      g  = (c >= 1 && c <= 6);
      r  = (c >= FC + 1 && c <= 6);
      v  = r && (c != 6);
      dn = (c == 7);
`else
      g  = (c >= 1 && c <= FC + 10);
      r  = (c >= FC + 1 && c <= FC + 10);
      v  = r;
      dn = (c == FC + 11);
`endif
      #4;
      e = exp_vec(0, g, r, v, dn);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL abort_drop c=%0d got=%h exp=%h", c, obs, e);
      end
      tick();
    end
  endtask

  // Timeline model: a job picked in an idle cycle s owns grant for s+1..s+FC+L,
  // is valid for s+FC+1..s+FC+L and completes at s+FC+L+1.
  task automatic test_random();
    int last, owner, start, mlen, d;
    bit busy, g, r, dn;
    logic [N-1:0] drop_next;
    logic [W-1:0] e;
    do_reset();
    last      = N - 1;
    busy      = 0;
    owner     = -1;
    start     = 0;
    mlen      = 0;
    drop_next = '0;
    for (int c = 0; c < 800; c++) begin
      req       = req & ~drop_next;
      drop_next = '0;
      for (int k = 0; k < N; k++) begin
        if (((req >> k) & N'(1)) == '0 && $urandom_range(3) == 0) req = req | (N'(1) << k);
      end
      for (int k = 0; k < N; k++) len[k*LW +: LW] = LW'($urandom_range(5));
      A_in = (N*M)'($urandom);
      B_in = (N*M)'($urandom);
      if (!busy) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (last + k) % N;
          if (!busy && ((req >> i) & N'(1)) != '0) begin
            busy  = 1;
            owner = i;
            start = c;
            mlen  = int'(LW'(len >> (i * LW)));
          end
        end
      end
      g  = 0;
      r  = 0;
      dn = 0;
      if (busy) begin
        d  = c - start;
        g  = (d >= 1 && d <= FC + mlen);
        r  = (d >= FC + 1 && d <= FC + mlen);
        dn = (d == FC + mlen + 1);
      end
      #4;
      e = exp_vec(busy ? owner : -1, g, r, r, dn);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL random c=%0d owner=%0d got=%h exp=%h", c, owner, obs, e);
      end
      if (busy && dn) begin
        last = owner;
        busy = 0;
        if ($urandom_range(1) == 1) drop_next = N'(1) << owner;
      end
      tick();
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_contention();
    test_fairness();
    test_zero_len();
    test_reset_mid_run();
    test_abort_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
